// File: rtl/core_pkg.sv
// core_pkg: shared RV32I core constants and the IF/ID latch record
package core_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_3000;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic            valid;
  } ifid_t;
endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter with redirect-over-stall next-PC selection
// ports: clk, rstn (sync, active-low), i_pc_stall, i_redirect_valid,
//        i_redirect_pc (low two bits ignored), o_pc (current PC)
module pc_reg #(
  parameter logic [core_pkg::XLEN-1:0] RESET_PC = core_pkg::RESET_PC
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      i_pc_stall,
  input  logic                      i_redirect_valid,
  input  logic [core_pkg::XLEN-1:0] i_redirect_pc,
  output logic [core_pkg::XLEN-1:0] o_pc
);
  logic [core_pkg::XLEN-1:0] r_pc;
  always_ff @(posedge clk)
    if (!rstn) r_pc <= RESET_PC;
    else if (i_redirect_valid) r_pc <= {i_redirect_pc[core_pkg::XLEN-1:2], 2'b00};
    else if (!i_pc_stall) r_pc <= r_pc + 32'd4;
  assign o_pc = r_pc;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch and IF/ID pipeline register
// ports: clk, rstn (sync, active-low), pc_stall, ifid_stall, ifid_flush,
//        redirect_valid/redirect_pc, imem_addr/imem_rdata (async-read imem),
//        pc_if, ir_id, pc_id, pc4_id, valid_id
// FETCH_PERF_CNT_EN adds perf_fetched and perf_bubbles counters
module fetch_stage #(
  parameter logic [core_pkg::XLEN-1:0] RESET_PC = core_pkg::RESET_PC,
  parameter logic [core_pkg::XLEN-1:0] NOP_INST = core_pkg::NOP_INST
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      pc_stall,
  input  logic                      ifid_stall,
  input  logic                      ifid_flush,
  input  logic                      redirect_valid,
  input  logic [core_pkg::XLEN-1:0] redirect_pc,
  output logic [core_pkg::XLEN-1:0] imem_addr,
  input  logic [core_pkg::XLEN-1:0] imem_rdata,
  output logic [core_pkg::XLEN-1:0] pc_if,
  output logic [core_pkg::XLEN-1:0] ir_id,
  output logic [core_pkg::XLEN-1:0] pc_id,
  output logic [core_pkg::XLEN-1:0] pc4_id,
  output logic                      valid_id
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [core_pkg::XLEN-1:0] perf_fetched,
  output logic [core_pkg::XLEN-1:0] perf_bubbles
`endif
);
  import core_pkg::*;
  logic [XLEN-1:0] w_pc;
  logic            w_bubble;
  logic            w_load;
  ifid_t           r_ifid;
  pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk              (clk),
    .rstn             (rstn),
    .i_pc_stall       (pc_stall),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_pc             (w_pc)
  );
  // a redirect squashes the wrong-path word being fetched this cycle
  assign w_bubble = ifid_flush | redirect_valid;
  assign w_load   = !w_bubble && !ifid_stall;
  always_ff @(posedge clk)
    if (!rstn || w_bubble) r_ifid <= '{ir: NOP_INST, pc: '0, pc4: 32'd4, valid: 1'b0};
    else if (!ifid_stall) r_ifid <= '{ir: imem_rdata, pc: w_pc, pc4: w_pc + 32'd4, valid: 1'b1};
  assign imem_addr = w_pc;
  assign pc_if     = w_pc;
  assign ir_id     = r_ifid.ir;
  assign pc_id     = r_ifid.pc;
  assign pc4_id    = r_ifid.pc4;
  assign valid_id  = r_ifid.valid;
`ifdef FETCH_PERF_CNT_EN
  logic [XLEN-1:0] r_fetched;
  logic [XLEN-1:0] r_bubbles;
  always_ff @(posedge clk)
    if (!rstn) begin
      r_fetched <= '0;
      r_bubbles <= '0;
    end else begin
      r_fetched <= r_fetched + {{(XLEN-1){1'b0}}, w_load};
      r_bubbles <= r_bubbles + {{(XLEN-1){1'b0}}, w_bubble};
    end
  assign perf_fetched = r_fetched;
  assign perf_bubbles = r_bubbles;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage with imem word = address
module tb_fetch_stage;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] pcid;
    logic [31:0] pc4;
    logic        v;
  } exp_t;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        pc_stall = 1'b0;
  logic        ifid_stall = 1'b0;
  logic        ifid_flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc_if;
  logic [31:0] ir_id;
  logic [31:0] pc_id;
  logic [31:0] pc4_id;
  logic        valid_id;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
`endif
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  exp_t m_e;
  fetch_stage dut (
    .clk            (clk),
    .rstn           (rstn),
    .pc_stall       (pc_stall),
    .ifid_stall     (ifid_stall),
    .ifid_flush     (ifid_flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .pc_if          (pc_if),
    .ir_id          (ir_id),
    .pc_id          (pc_id),
    .pc4_id         (pc4_id),
    .valid_id       (valid_id)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_bubbles   (perf_bubbles)
`endif
  );
  assign imem_rdata = imem_addr;
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] b);
    checks++;
    if (a !== b) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, a, b);
    end
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      m_e = q.pop_front();
      chk("pc_if", pc_if, m_e.pc);
      chk("imem_addr", imem_addr, m_e.pc);
      chk("ir_id", ir_id, m_e.ir);
      chk("pc_id", pc_id, m_e.pcid);
      chk("pc4_id", pc4_id, m_e.pc4);
      chk("valid_id", {31'd0, valid_id}, {31'd0, m_e.v});
    end
  task automatic cyc(input logic rn, input logic ps, input logic is, input logic fl,
                     input logic rv, input logic [31:0] rpc,
                     input logic [31:0] ep, input logic [31:0] ei,
                     input logic [31:0] epi, input logic [31:0] ep4, input logic ev);
    rstn = rn;
    pc_stall = ps;
    ifid_stall = is;
    ifid_flush = fl;
    redirect_valid = rv;
    redirect_pc = rpc;
    @(posedge clk);
    q.push_back('{ep, ei, epi, ep4, ev});
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    cyc(0, 0, 0, 0, 0, 0, 32'h3000, 32'h13, 32'h0, 32'h4, 0);
    cyc(0, 0, 0, 0, 0, 0, 32'h3000, 32'h13, 32'h0, 32'h4, 0);
    cyc(1, 0, 0, 0, 0, 0, 32'h3004, 32'h3000, 32'h3000, 32'h3004, 1);
    cyc(1, 0, 0, 0, 0, 0, 32'h3008, 32'h3004, 32'h3004, 32'h3008, 1);
    cyc(1, 0, 0, 0, 0, 0, 32'h300c, 32'h3008, 32'h3008, 32'h300c, 1);
    cyc(1, 0, 0, 0, 0, 0, 32'h3010, 32'h300c, 32'h300c, 32'h3010, 1);
    for (int i = 0; i < 3; i++)
      cyc(1, 1, 1, 0, 0, 0, 32'h3010, 32'h300c, 32'h300c, 32'h3010, 1);
    cyc(1, 0, 0, 0, 0, 0, 32'h3014, 32'h3010, 32'h3010, 32'h3014, 1);
    cyc(1, 1, 0, 0, 1, 32'h3100, 32'h3100, 32'h13, 32'h0, 32'h4, 0);
    cyc(1, 0, 0, 0, 0, 0, 32'h3104, 32'h3100, 32'h3100, 32'h3104, 1);
    cyc(1, 0, 1, 1, 0, 0, 32'h3108, 32'h13, 32'h0, 32'h4, 0);
    cyc(1, 1, 1, 1, 0, 0, 32'h3108, 32'h13, 32'h0, 32'h4, 0);
    cyc(1, 1, 0, 0, 0, 0, 32'h3108, 32'h3108, 32'h3108, 32'h310c, 1);
    cyc(1, 1, 0, 0, 0, 0, 32'h3108, 32'h3108, 32'h3108, 32'h310c, 1);
    cyc(1, 0, 0, 0, 0, 0, 32'h310c, 32'h3108, 32'h3108, 32'h310c, 1);
    cyc(1, 0, 0, 0, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h13, 32'h0, 32'h4, 0);
    cyc(1, 0, 0, 0, 0, 0, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 1);
    cyc(1, 0, 0, 0, 0, 0, 32'h4, 32'h0, 32'h0, 32'h4, 1);
    cyc(1, 0, 1, 0, 0, 0, 32'h8, 32'h0, 32'h0, 32'h4, 1);
    cyc(1, 0, 0, 0, 0, 0, 32'hc, 32'h8, 32'h8, 32'hc, 1);
    cyc(0, 1, 1, 0, 1, 32'h5000, 32'h3000, 32'h13, 32'h0, 32'h4, 0);
    cyc(1, 0, 0, 0, 0, 0, 32'h3004, 32'h3000, 32'h3000, 32'h3004, 1);
    cyc(0, 0, 0, 0, 0, 0, 32'h3000, 32'h13, 32'h0, 32'h4, 0);
    for (int i = 0; i < 10; i++)
      cyc(1, 0, 0, 0, 0, 0, 32'h3004 + 32'(4 * i), 32'h3000 + 32'(4 * i),
          32'h3000 + 32'(4 * i), 32'h3004 + 32'(4 * i), 1);
    cyc(1, 0, 0, 0, 1, 32'h3200, 32'h3200, 32'h13, 32'h0, 32'h4, 0);
    @(negedge clk);
    #1;
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, 32'd10);
    chk("perf_bubbles", perf_bubbles, 32'd1);
`endif
    cyc(0, 0, 0, 0, 0, 0, 32'h3000, 32'h13, 32'h0, 32'h4, 0);
    @(negedge clk);
    #1;
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched_rst", perf_fetched, 32'd0);
    chk("perf_bubbles_rst", perf_bubbles, 32'd0);
`endif
    chk("queue_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the five-stage RV32I core. It holds the PC, addresses the asynchronous-read instruction memory, and registers the fetched word together with its PC and PC+4 into the IF/ID latch. The control unit decodes the latched `ir_id` in ID. Stall, flush and branch/jump redirect requests from the hazard unit and the EX stage are resolved here under a fixed priority.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000, PC value after reset.
- `NOP_INST`, 32'h0000_0013, bubble instruction (`addi x0,x0,0`) inserted on reset and flush.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `pc_stall`  in  1  hold the PC (load-use hazard).
- `ifid_stall`  in  1  hold the IF/ID register.
- `ifid_flush`  in  1  load a bubble into IF/ID.
- `redirect_valid`  in  1  taken branch, `jal` or `jalr` resolved in EX.
- `redirect_pc`  in  32  target of the redirect.
- `imem_addr`  out  32  instruction memory address. Equals the current PC, combinational.
- `imem_rdata`  in  32  instruction word, valid in the same cycle as `imem_addr`.
- `pc_if`  out  32  current PC.
- `ir_id`  out  32  latched instruction for decode.
- `pc_id`  out  32  PC of `ir_id`.
- `pc4_id`  out  32  `pc_id`+4, used as the link value for `jal`/`jalr`.
- `valid_id`  out  1  `ir_id` is a real instruction, not a bubble.

## Operation
- PC next-state, highest priority first:
  - `!rstn` → `RESET_PC`
  - `redirect_valid` → `redirect_pc`
  - `pc_stall` → hold
  - otherwise → PC+4
- A redirect overrides `pc_stall`: the stalled instruction is on the wrong path and is discarded.
- IF/ID next-state, highest priority first:
  - `!rstn` → {`NOP_INST`, 0, 4, valid=0}
  - `ifid_flush` or `redirect_valid` → {`NOP_INST`, 0, 4, valid=0}
  - `ifid_stall` → hold all fields
  - otherwise → {`imem_rdata`, PC, PC+4, valid=1}
- Flush beats stall on the same edge.
- PC+4 and `redirect_pc` are used modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- `redirect_pc[1:0]` is forced to 00 before loading the PC. No misalignment trap is raised.
- `pc_stall` without `ifid_stall` is legal: IF/ID then re-latches the same PC every cycle.

## Timing
- Reset values: PC=`RESET_PC`, `ir_id`=`NOP_INST`, `pc_id`=0, `pc4_id`=4, `valid_id`=0. Perf counters are 0.
- Reset asserted mid-stream overrides every other input on that edge.
- First real instruction: `valid_id`=1 one cycle after `rstn` rises. `pc_id`=`RESET_PC` on that cycle.
- Fetch latency: the word at PC appears on `ir_id` one edge after PC is presented.
- Redirect sampled at edge N:
  - PC=target after edge N.
  - The bubble is in IF/ID after edge N.
  - The target instruction is in IF/ID after edge N+1.
- The EX stage flushes its own ID/EX latch. Total branch penalty is 2 cycles.
- `imem_addr` has no registered delay. It changes only on clock edges.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - Adds output `perf_fetched` (32): increments on every edge where IF/ID loads a valid instruction.
  - Adds output `perf_bubbles` (32): increments on every edge where IF/ID loads a flush or redirect bubble.
  - Both counters wrap at 2^32 and reset to 0 on `!rstn`.
- Undefined: neither counter port nor counter logic exists.

## Structure
- Shared package `core_pkg` holds:
  - `RESET_PC` and `NOP_INST`
  - the `ifid_t` struct {`ir`, `pc`, `pc4`, `valid`}
  - `XLEN`=32
- One sub-module, `pc_reg`: PC register plus next-PC mux with redirect/stall priority.
- IF/ID latch and perf counters stay in `fetch_stage`.

## Test plan
- Reset then free run, imem word = address:
  - Cycle 1: `pc_id`=0x3000, `ir_id`=0x3000, `valid_id`=1.
  - Cycle 2: `pc_id`=0x3004, `pc4_id`=0x3008.
- `pc_stall`=`ifid_stall`=1 for 3 cycles at PC=0x3010: PC, `ir_id` and `pc_id` unchanged for 3 cycles. 0x3014 follows after release.
- `redirect_valid`=1, `redirect_pc`=0x3100, with `pc_stall`=1 on the same cycle:
  - Next cycle: PC=0x3100 and `valid_id`=0, `ir_id`=0x13.
  - Cycle after: `pc_id`=0x3100.
- `ifid_flush`=1 with `ifid_stall`=1: IF/ID becomes the bubble (`valid_id`=0); PC advances unless `pc_stall`.
- Wrap: `redirect_pc`=0xFFFF_FFFE:
  - PC=0xFFFF_FFFC.
  - Next PC=0, and `pc4_id` for that fetch=0.
- With `FETCH_PERF_CNT_EN`: 10 free-run cycles and 1 redirect → `perf_fetched`=10, `perf_bubbles`=1. Asserting `rstn`=0 mid-run clears both counters on the next edge.
